// File: rtl/fetch_interrupt_latch_pkg.sv
// Shared control-logic definitions: interrupt kinds, the injected BRK opcode
// and the vector addresses the state machine jumps through.
package fetch_interrupt_latch_pkg;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_RESET = 2'd1,
    KIND_NMI   = 2'd2,
    KIND_IRQ   = 2'd3
  } interruptKind_e;

  localparam logic [7:0]  BRK_OPCODE = 8'h00;
  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RESET  = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;

  // Software BRK (kind NONE) shares the IRQ vector.
  function automatic logic [15:0] vectorFor(interruptKind_e kind);
    case (kind)
      KIND_RESET: return VEC_RESET;
      KIND_NMI:   return VEC_NMI;
      default:    return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/fetch_interrupt_latch_interrupt_input_sync.sv
// Interrupt pin conditioning: optional 2-flop synchronizers (INTERRUPT_SYNC_EN)
// followed by the NMI falling-edge detector and the IRQ level output.
module interrupt_input_sync (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic irq_n,
  output logic nmiEdge,
  output logic irqLevel
);

  logic nmiIn;
  logic irqIn;
  logic nmiPrev_q;

`ifdef INTERRUPT_SYNC_EN
  logic [1:0] nmiSync_q;
  logic [1:0] irqSync_q;

  // Synchronizers reset to the inactive (high) pin level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmiSync_q <= 2'b11;
      irqSync_q <= 2'b11;
    end else begin
      nmiSync_q <= {nmiSync_q[0], nmi_n};
      irqSync_q <= {irqSync_q[0], irq_n};
    end
  end

  assign nmiIn = nmiSync_q[1];
  assign irqIn = irqSync_q[1];
`else
  assign nmiIn = nmi_n;
  assign irqIn = irq_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmiPrev_q <= 1'b1;
    end else begin
      nmiPrev_q <= nmiIn;
    end
  end

  assign nmiEdge  = nmiPrev_q & ~nmiIn;
  assign irqLevel = ~irqIn;

endmodule

// File: rtl/fetch_interrupt_latch.sv
// Opcode fetch latch with reset/NMI/IRQ BRK injection and registered RDY.
// Build option: INTERRUPT_SYNC_EN adds pin synchronizers in interrupt_input_sync.
module fetch_interrupt_latch
  import fetch_interrupt_latch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dataBus,
  input  logic        ready,
  input  logic        getInstruction,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        irqMask,
  output logic [7:0]  opcode,
  output logic        injectBrk,
  output logic [1:0]  interruptKind,
  output logic [15:0] vectorAddr,
  output logic        enableFFs
);

  logic           nmiEdge;
  logic           irqLevel;
  logic           irqReq;
  logic           fetch;

  logic           readyQ_q;
  logic [7:0]     opcode_q, opcode_d;
  logic           injectBrk_q, injectBrk_d;
  interruptKind_e kind_q, kind_d;
  logic           resetPending_q, resetPending_d;
  logic           nmiPending_q, nmiPending_d;

  interrupt_input_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .nmiEdge  (nmiEdge),
    .irqLevel (irqLevel)
  );

  assign irqReq = irqLevel & ~irqMask;
  assign fetch  = getInstruction & readyQ_q;

  // Priority reset > NMI > IRQ > normal; a new NMI edge overrides the clear.
  always_comb begin
    opcode_d       = opcode_q;
    injectBrk_d    = injectBrk_q;
    kind_d         = kind_q;
    resetPending_d = resetPending_q;
    nmiPending_d   = nmiPending_q;
    if (fetch) begin
      if (resetPending_q) begin
        opcode_d       = BRK_OPCODE;
        injectBrk_d    = 1'b1;
        kind_d         = KIND_RESET;
        resetPending_d = 1'b0;
      end else if (nmiPending_q) begin
        opcode_d     = BRK_OPCODE;
        injectBrk_d  = 1'b1;
        kind_d       = KIND_NMI;
        nmiPending_d = 1'b0;
      end else if (irqReq) begin
        opcode_d    = BRK_OPCODE;
        injectBrk_d = 1'b1;
        kind_d      = KIND_IRQ;
      end else begin
        opcode_d    = dataBus;
        injectBrk_d = 1'b0;
        kind_d      = KIND_NONE;
      end
    end
    if (nmiEdge) begin
      nmiPending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readyQ_q       <= 1'b0;
      opcode_q       <= BRK_OPCODE;
      injectBrk_q    <= 1'b0;
      kind_q         <= KIND_NONE;
      resetPending_q <= 1'b1;
      nmiPending_q   <= 1'b0;
    end else begin
      readyQ_q       <= ready;
      opcode_q       <= opcode_d;
      injectBrk_q    <= injectBrk_d;
      kind_q         <= kind_d;
      resetPending_q <= resetPending_d;
      nmiPending_q   <= nmiPending_d;
    end
  end

  assign opcode        = opcode_q;
  assign injectBrk     = injectBrk_q;
  assign interruptKind = kind_q;
  assign vectorAddr    = vectorFor(kind_q);
  assign enableFFs     = readyQ_q;

endmodule

// File: doc/fetch_interrupt_latch.md
Name: fetch_interrupt_latch

Overview:
- Sits directly upstream of the control-logic state machine.
- Latches the opcode byte from the data bus on each opcode-fetch cycle and feeds the decoder.
- Substitutes a forced BRK (8'h00) when a reset, NMI or IRQ sequence is pending.
- Registers the external RDY line to produce enableFFs for the whole control path.

Parameters:
- BRK_OPCODE, 8'h00, opcode injected for reset/NMI/IRQ sequences
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RESET, 16'hFFFC, reset vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- dataBus  input  8  byte returned by memory in the current cycle
- ready  input  1  external RDY, high = memory ready
- getInstruction  input  1  from state machine; high in the opcode-fetch cycle
- nmi_n  input  1  NMI pin, active-low, edge-triggered
- irq_n  input  1  IRQ pin, active-low, level-sensitive
- irqMask  input  1  processor I flag; 1 masks IRQ
- opcode  output  8  latched opcode to decoder
- injectBrk  output  1  1 = current opcode was injected, not fetched
- interruptKind  output  2  NONE=0, RESET=1, NMI=2, IRQ=3 for the current instruction
- vectorAddr  output  16  vector address selected by interruptKind
- enableFFs  output  1  registered ready; gates all control-path flops

Behaviour:
- Reset (async, rst=1) forces: opcode=8'h00, injectBrk=0, interruptKind=NONE, readyQ=0 (so enableFFs=0), nmiPrev=1, nmiPending=0, resetPending=1.
- Reset asserted mid-instruction aborts it. State returns to the values above; nothing is preserved.
- enableFFs = readyQ, where readyQ <= ready every clock. Latency is 1 cycle; no combinational path from ready to enableFFs.
- NMI edge detect runs every clock, independent of enableFFs:
  - nmiPrev <= nmi_n.
  - A falling edge (nmiPrev=1, nmi_n=0) sets nmiPending on the next edge.
  - A low level held on nmi_n does not re-trigger.
- irqReq = ~irq_n & ~irqMask, evaluated combinationally in the fetch cycle. IRQ is not latched.
- Fetch event = getInstruction & enableFFs. On a fetch event, priority is resetPending > nmiPending > irqReq > normal:
  - Injected: opcode <= BRK_OPCODE, injectBrk <= 1, interruptKind <= kind, and the winning pending bit is cleared.
  - Normal: opcode <= dataBus, injectBrk <= 0, interruptKind <= NONE.
- Fetch uses pending values from before the current edge. An NMI edge detected in the fetch cycle is serviced at the next fetch.
- If a fetch clears nmiPending in the same cycle a new NMI edge is seen, set wins and nmiPending stays 1.
- Outside fetch events, opcode, injectBrk and interruptKind hold.
- With getInstruction=1 and enableFFs=0, nothing is latched and pending bits hold. The NMI edge detector still runs.
- vectorAddr is combinational from interruptKind: RESET -> VEC_RESET, NMI -> VEC_NMI, NONE/IRQ -> VEC_IRQ (software BRK shares the IRQ vector).

Optional Feature:
- Macro: INTERRUPT_SYNC_EN.
- Defined: nmi_n and irq_n each pass through a 2-flop synchronizer (reset value 1) before edge detect and irqReq. NMI and IRQ recognition latency grows by 2 cycles.
- Undefined: pins are used directly; the inputs must already be synchronous to clk.

Decomposition:
- Shared package (control-logic package): the interruptKind enum (NONE/RESET/NMI/IRQ), BRK_OPCODE, and the three vector constants. The state machine uses the same enum.
- One sub-module: interrupt_input_sync. It contains the optional synchronizer plus the NMI falling-edge detector and outputs nmiEdge and irqLevel.

Test Plan:
- Power-up: rst=1 then 0, ready=1, dataBus=8'hA9, getInstruction pulsed -> opcode=8'h00, injectBrk=1, interruptKind=RESET, vectorAddr=16'hFFFC. Second fetch -> opcode=8'hA9, injectBrk=0, kind=NONE.
- NMI edge: nmi_n 1->0 held low 10 cycles, then two fetches -> first fetch injects kind=NMI, vector 16'hFFFA. Second fetch is normal (no re-trigger on level).
- IRQ masking: irq_n=0, irqMask=1, fetch with dataBus=8'hEA -> opcode=8'hEA. Same with irqMask=0 -> opcode=8'h00, kind=IRQ, vector 16'hFFFE.
- Priority: nmiPending set and irqReq active in the same fetch -> kind=NMI. Next fetch with irq still low -> kind=IRQ.
- RDY stall: ready=0 for 3 cycles -> enableFFs low 3 cycles, delayed by 1. Fetch during the stall leaves opcode unchanged; an NMI edge during the stall is still captured.
- Mid-run reset: rst pulsed while kind=NMI -> all outputs return to reset values immediately. The next fetch injects RESET.
